// File: rtl/data_mem_port.sv
// data_mem_port: load/store access unit between the core memory stage and a
// word-wide data memory with a req/ack handshake. It builds word-aligned
// transactions with byte enables, lane-shifts store data, extracts and extends
// load data, and stalls the core until the access completes.
//
// Optional feature macro: DMEM_MISALIGNED_EN
//   defined   - accesses that cross a word boundary are split into two
//               transactions (ACC1 + ACC2) and complete normally.
//   undefined - misaligned accesses complete at once with rdata=0 and no
//               memory transaction.
// misalign pulses with done for any access that is not naturally aligned.
module data_mem_port #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [2:0]        addrmode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              done,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

`ifdef DMEM_MISALIGNED_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    state_t            state_q;
    size_t             size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic              mis_q;
    logic              split_q;
    logic [3:0]        be2_q;
    logic [31:0]       wdata2_q;
    logic [31:0]       word1_q;

    logic [31:0]       rdata_q;
    logic              done_q;
    logic              misalign_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;

    size_t             reqSize;
    logic              reqUns;
    logic [1:0]        reqOff;
    logic              reqMis;
    logic              reqSplit;
    logic [3:0]        beBase;
    logic [63:0]       dataBase;
    logic [7:0]        beWide;
    logic [63:0]       dataWide;
    logic [ADDR_W-1:0] wordAddr;

    // Pick the addressed bytes out of the two-word window and extend them.
    function automatic logic [31:0] extract(input logic [63:0] win,
                                            input logic [1:0]  off,
                                            input size_t       size,
                                            input logic        uns);
        logic [31:0] s;
        logic [31:0] r;
        s = 32'(win >> {off, 3'b000});
        case (size)
            SZ_BYTE: r = uns ? {24'h0, s[7:0]}   : {{24{s[7]}}, s[7:0]};
            SZ_HALF: r = uns ? {16'h0, s[15:0]}  : {{16{s[15]}}, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    assign wordAddr = {addr[ADDR_W-1:2], 2'b00};

    // Decode the incoming request: size, alignment, and the lane layout
    // of both words (the high half of the wide vectors feeds the ACC2 word).
    always_comb begin
        reqSize = SZ_WORD;
        if (!addrmode[1]) begin
            reqSize = addrmode[0] ? SZ_HALF : SZ_BYTE;
        end
        reqUns   = addrmode[2] & ~addrmode[1];
        reqOff   = addr[1:0];
        beBase   = 4'b0000;
        dataBase = 64'h0;
        reqMis   = 1'b0;
        reqSplit = 1'b0;
        case (reqSize)
            SZ_BYTE: begin
                beBase   = 4'b0001;
                dataBase = {32'h0, {4{wdata[7:0]}}};
            end
            SZ_HALF: begin
                beBase   = 4'b0011;
                dataBase = {48'h0, wdata[15:0]};
                reqMis   = reqOff[0];
                reqSplit = (reqOff == 2'b11);
            end
            default: begin
                beBase   = 4'b1111;
                dataBase = {32'h0, wdata};
                reqMis   = (reqOff != 2'b00);
                reqSplit = reqMis;
            end
        endcase
        reqSplit = reqSplit & SplitEn;
        beWide   = {4'b0000, beBase} << reqOff;
        dataWide = (reqSize == SZ_BYTE) ? dataBase : (dataBase << {reqOff, 3'b000});
    end

    // Access sequencer: latches the request, runs one or two handshakes,
    // and presents the registered result for exactly one DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            mis_q       <= 1'b0;
            split_q     <= 1'b0;
            be2_q       <= 4'b0000;
            wdata2_q    <= 32'h0;
            word1_q     <= 32'h0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (memread || memwrite) begin
                        size_q   <= reqSize;
                        uns_q    <= reqUns;
                        off_q    <= reqOff;
                        mis_q    <= reqMis;
                        split_q  <= reqSplit;
                        be2_q    <= beWide[7:4];
                        wdata2_q <= dataWide[63:32];
                        if (reqMis && !SplitEn) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                            rdata_q    <= 32'h0;
                        end else begin
                            state_q     <= ACC1;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= memwrite;
                            mem_addr_q  <= wordAddr;
                            mem_be_q    <= beWide[3:0];
                            mem_wdata_q <= dataWide[31:0];
                        end
                    end
                end
                ACC1: begin
                    if (mem_ack) begin
                        if (split_q) begin
                            state_q     <= ACC2;
                            word1_q     <= mem_rdata;
                            mem_addr_q  <= mem_addr_q + ADDR_W'(4);
                            mem_be_q    <= be2_q;
                            mem_wdata_q <= wdata2_q;
                        end else begin
                            state_q    <= DONE;
                            mem_req_q  <= 1'b0;
                            done_q     <= 1'b1;
                            misalign_q <= mis_q;
                            rdata_q    <= mem_we_q ? 32'h0
                                        : extract({32'h0, mem_rdata}, off_q, size_q, uns_q);
                        end
                    end
                end
                ACC2: begin
                    if (mem_ack) begin
                        state_q    <= DONE;
                        mem_req_q  <= 1'b0;
                        done_q     <= 1'b1;
                        misalign_q <= mis_q;
                        rdata_q    <= mem_we_q ? 32'h0
                                    : extract({mem_rdata, word1_q}, off_q, size_q, uns_q);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall covers the request cycle in IDLE and every handshake cycle.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            stall = ((state_q == IDLE) && (memread || memwrite))
                  || (state_q == ACC1) || (state_q == ACC2);
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign misalign  = misalign_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Testbench for data_mem_port: word memory responder with programmable ack
// latency, a table of directed load/store vectors, and hand-written reset
// sequences. Expectations follow DMEM_MISALIGNED_EN when it is defined.
module tb_data_mem_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [2:0]  addrmode = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    data_mem_port #(.ADDR_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .memread  (memread),
        .memwrite (memwrite),
        .addrmode (addrmode),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .done     (done),
        .misalign (misalign),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_be   (mem_be),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after waitCycles idle cycles per transaction.
    logic [31:0] memArr [int unsigned];
    logic [31:0] reqLog [$];
    int          waitCycles = 0;
    int          ackCnt = 0;
    bit          blockAck = 1'b0;
    bit          forceAck = 1'b0;
    bit          prevAck = 1'b0;

    always @(negedge clk) begin
        prevAck = mem_ack;
        mem_ack = 1'b0;
        if (forceAck) begin
            mem_ack = 1'b1;
        end else begin
            if (!mem_req || prevAck) ackCnt = waitCycles;
            if (mem_req && !blockAck) begin
                if (ackCnt == 0) begin
                    logic [31:0] w;
                    w = memArr.exists(mem_addr) ? memArr[mem_addr] : 32'h0;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
                        memArr[mem_addr] = w;
                    end
                    mem_rdata = w;
                    mem_ack   = 1'b1;
                    reqLog.push_back(mem_addr);
                end else begin
                    ackCnt--;
                end
            end
        end
    end

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre;
        logic [31:0] preData;
        int          wt;
        int          stalls;
        int          nreq;
        logic        mis;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWd;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] mode, logic [31:0] a,
                                logic [31:0] wd, logic pre, logic [31:0] preData, int wt,
                                int stalls, int nreq, logic mis, logic [31:0] expAddr,
                                logic [3:0] expBe, logic [31:0] expWd, logic [31:0] expRd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.mode = mode; v.addr = a; v.wdata = wd;
        v.pre = pre; v.preData = preData; v.wt = wt; v.stalls = stalls;
        v.nreq = nreq; v.mis = mis; v.expAddr = expAddr; v.expBe = expBe;
        v.expWd = expWd; v.expRd = expRd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    int          stallCnt;
    bit          gotDone;
    bit          seenReq;
    int          unstable;
    logic [31:0] resRdata;
    logic        resMis;
    logic [31:0] fAddr;
    logic [31:0] fWd;
    logic [3:0]  fBe;
    logic        fWe;

    // Present one request, hold it until done, and record what was observed.
    task automatic applyStimulus(input vec_t v);
        if (v.pre) memArr[v.addr & ~32'h3] = v.preData;
        waitCycles = v.wt;
        reqLog.delete();
        @(posedge clk); #1;
        memread  = v.rd;
        memwrite = v.wr;
        addrmode = v.mode;
        addr     = v.addr;
        wdata    = v.wdata;
        stallCnt = 0; gotDone = 0; seenReq = 0; unstable = 0;
        resRdata = 32'hx; resMis = 1'bx;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done) begin
                gotDone  = 1;
                resRdata = rdata;
                resMis   = misalign;
                break;
            end
            if (stall) stallCnt++;
            if (mem_req) begin
                if (!seenReq) begin
                    seenReq = 1;
                    fAddr = mem_addr; fBe = mem_be; fWd = mem_wdata; fWe = mem_we;
                end else if (reqLog.size() == 0 &&
                             {mem_addr, mem_be, mem_wdata, mem_we} != {fAddr, fBe, fWd, fWe}) begin
                    unstable++;
                end
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    int doneSeen;
    int reqSeen;

    initial begin
        memArr[32'h1FC] = 32'h44332211;
        memArr[32'h200] = 32'h88776655;

        vecs.push_back(mk(1,0,3'b010,32'h100,0,        1,32'hDEADBEEF,0, 2,1,0,32'h100,0,0,32'hDEADBEEF));
        vecs.push_back(mk(1,0,3'b000,32'h103,0,        1,32'h80FF0000,0, 2,1,0,32'h100,0,0,32'hFFFFFF80));
        vecs.push_back(mk(1,0,3'b100,32'h103,0,        0,0,           0, 2,1,0,32'h100,0,0,32'h00000080));
        vecs.push_back(mk(1,0,3'b001,32'h102,0,        0,0,           0, 2,1,0,32'h100,0,0,32'hFFFF80FF));
        vecs.push_back(mk(1,0,3'b101,32'h102,0,        0,0,           0, 2,1,0,32'h100,0,0,32'h000080FF));
        vecs.push_back(mk(1,0,3'b000,32'h102,0,        0,0,           0, 2,1,0,32'h100,0,0,32'hFFFFFFFF));
        vecs.push_back(mk(1,0,3'b011,32'h100,0,        0,0,           0, 2,1,0,32'h100,0,0,32'h80FF0000));
        vecs.push_back(mk(1,0,3'b001,32'h100,0,        1,32'h00007FFE,0, 2,1,0,32'h100,0,0,32'h00007FFE));
`ifdef DMEM_MISALIGNED_EN
        vecs.push_back(mk(1,0,3'b010,32'h1FE,0,        0,0,           0, 3,2,1,32'h1FC,0,0,32'h66554433));
        vecs.push_back(mk(1,0,3'b001,32'h1FF,0,        0,0,           0, 3,2,1,32'h1FC,0,0,32'h00005544));
        vecs.push_back(mk(1,0,3'b101,32'h1FD,0,        0,0,           0, 2,1,1,32'h1FC,0,0,32'h00003322));
`else
        vecs.push_back(mk(1,0,3'b010,32'h1FE,0,        0,0,           0, 1,0,1,0,0,0,32'h0));
        vecs.push_back(mk(1,0,3'b001,32'h1FF,0,        0,0,           0, 1,0,1,0,0,0,32'h0));
        vecs.push_back(mk(1,0,3'b101,32'h1FD,0,        0,0,           0, 1,0,1,0,0,0,32'h0));
`endif
        vecs.push_back(mk(0,1,3'b001,32'h202,32'h1234ABCD,0,0,     0, 2,1,0,32'h200,4'b1100,32'hABCD0000,0));
        vecs.push_back(mk(0,1,3'b000,32'h201,32'h000000A5,0,0,     0, 2,1,0,32'h200,4'b0010,32'hA5A5A5A5,0));
        vecs.push_back(mk(1,0,3'b010,32'h200,0,        0,0,           0, 2,1,0,32'h200,0,0,32'hABCDA555));
        vecs.push_back(mk(0,1,3'b010,32'h204,32'hCAFEF00D,0,0,     0, 2,1,0,32'h204,4'b1111,32'hCAFEF00D,0));
        vecs.push_back(mk(1,1,3'b010,32'h208,32'h11223344,0,0,     0, 2,1,0,32'h208,4'b1111,32'h11223344,0));
        vecs.push_back(mk(1,0,3'b010,32'h208,0,        0,0,           0, 2,1,0,32'h208,0,0,32'h11223344));
`ifdef DMEM_MISALIGNED_EN
        vecs.push_back(mk(0,1,3'b010,32'h3FE,32'hA1B2C3D4,0,0,     0, 3,2,1,32'h3FC,4'b1100,32'hC3D40000,0));
        vecs.push_back(mk(1,0,3'b010,32'h400,0,        0,0,           0, 2,1,0,32'h400,0,0,32'h0000A1B2));
        vecs.push_back(mk(1,0,3'b010,32'h3FC,0,        0,0,           0, 2,1,0,32'h3FC,0,0,32'hC3D40000));
`else
        vecs.push_back(mk(0,1,3'b010,32'h3FE,32'hA1B2C3D4,0,0,     0, 1,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,3'b010,32'h400,0,        0,0,           0, 2,1,0,32'h400,0,0,32'h0));
        vecs.push_back(mk(1,0,3'b010,32'h3FC,0,        0,0,           0, 2,1,0,32'h3FC,0,0,32'h0));
`endif
        vecs.push_back(mk(0,1,3'b000,32'h3FF,32'h0000007E,0,0,     0, 2,1,0,32'h3FC,4'b1000,32'h7E7E7E7E,0));
        vecs.push_back(mk(1,0,3'b100,32'h3FF,0,        0,0,           0, 2,1,0,32'h3FC,0,0,32'h0000007E));
        vecs.push_back(mk(1,0,3'b010,32'h100,0,        1,32'h0BADF00D,4, 6,1,0,32'h100,0,0,32'h0BADF00D));
`ifdef DMEM_MISALIGNED_EN
        vecs.push_back(mk(1,0,3'b010,32'h1FE,0,        0,0,           1, 5,2,1,32'h1FC,0,0,32'hA5554433));
`else
        vecs.push_back(mk(1,0,3'b010,32'h1FE,0,        0,0,           1, 1,0,1,0,0,0,32'h0));
`endif

        // Reset values, with a pending request to show stall is gated by rst.
        memread = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.stall",    32'(stall),    32'h0);
        checkOutput("rst.rdata",    rdata,         32'h0);
        checkOutput("rst.done",     32'(done),     32'h0);
        checkOutput("rst.misalign", 32'(misalign), 32'h0);
        checkOutput("rst.mem_req",  32'(mem_req),  32'h0);
        checkOutput("rst.mem_we",   32'(mem_we),   32'h0);
        checkOutput("rst.mem_be",   32'(mem_be),   32'h0);
        checkOutput("rst.mem_addr", mem_addr,      32'h0);
        checkOutput("rst.mem_wdata",mem_wdata,     32'h0);
        memread = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d.done", i),     32'(gotDone),      32'h1);
            checkOutput($sformatf("v%0d.stalls", i),   32'(stallCnt),     32'(vecs[i].stalls));
            checkOutput($sformatf("v%0d.misalign", i), 32'(resMis),       32'(vecs[i].mis));
            checkOutput($sformatf("v%0d.nreq", i),     32'(reqLog.size()),32'(vecs[i].nreq));
            if (vecs[i].rd && !vecs[i].wr)
                checkOutput($sformatf("v%0d.rdata", i), resRdata, vecs[i].expRd);
            if (vecs[i].nreq > 0) begin
                checkOutput($sformatf("v%0d.addr", i),   fAddr,          vecs[i].expAddr);
                checkOutput($sformatf("v%0d.we", i),     32'(fWe),       32'(vecs[i].wr));
                checkOutput($sformatf("v%0d.stable", i), 32'(unstable),  32'h0);
                if (vecs[i].wr) begin
                    checkOutput($sformatf("v%0d.be", i),    32'(fBe), 32'(vecs[i].expBe));
                    checkOutput($sformatf("v%0d.wdata", i), fWd,      vecs[i].expWd);
                end
                if (vecs[i].nreq == 2 && reqLog.size() == 2)
                    checkOutput($sformatf("v%0d.addr2", i), reqLog[1], vecs[i].expAddr + 32'h4);
            end
        end

        // Reset in the middle of an unacknowledged request.
        waitCycles = 0;
        blockAck = 1'b1;
        @(posedge clk); #1;
        memread = 1'b1; addrmode = 3'b010; addr = 32'h104;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstmid.req_before",   32'(mem_req), 32'h1);
        checkOutput("rstmid.stall_before", 32'(stall),   32'h1);
        rst = 1'b1;
        memread = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstmid.req_after",   32'(mem_req), 32'h0);
        checkOutput("rstmid.stall_after", 32'(stall),   32'h0);
        rst = 1'b0;
        blockAck = 1'b0;
        forceAck = 1'b1;
        doneSeen = 0;
        reqSeen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done) doneSeen++;
            if (mem_req) reqSeen++;
        end
        forceAck = 1'b0;
        checkOutput("rstmid.late_ack_done", 32'(doneSeen), 32'h0);
        checkOutput("rstmid.late_ack_req",  32'(reqSeen),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
